// File: rtl/rv32e_instruction_encoder_if.sv
// rv32e_instruction_encoder_if: request and result streams of the RV32E encoder.
interface rv32e_instruction_encoder_if #(parameter int CNT_W = 16);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_class;
    logic [4:0]       in_rd;
    logic [4:0]       in_rs1;
    logic [4:0]       in_rs2;
    logic [2:0]       in_funct3;
    logic             in_alt;
    logic [31:0]      in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             out_err;
    logic [CNT_W-1:0] enc_count;
    logic [CNT_W-1:0] err_count;
    modport slave (
        input  in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_alt, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_err, enc_count, err_count
    );
    modport master (
        output in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_alt, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_err, enc_count, err_count
    );
endinterface

// File: rtl/rv32e_instruction_encoder.sv
// rv32e_instruction_encoder: packs decoded RV32E micro-op fields into instruction words,
// flags illegal requests, and queues results in an output FIFO.
module rv32e_instruction_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst_n,
    rv32e_instruction_encoder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    logic [3:0]         c;
    logic [2:0]         f3, f3_f;
    logic [31:0]        imm, word;
    logic signed [31:0] simm;
    logic               alt, u_rd, u_rs1, u_rs2, is_shift, i_ok;
    logic               reg_bad, f3_bad, imm_bad, alt_bad, err;
    logic [6:0]         opc;
    logic [4:0]         rd, rs1, rs2;
    logic [32:0]        mem_q [DEPTH];
    logic [32:0]        head;
    logic [AW-1:0]      wp_q, rp_q;
    logic [AW:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]   enc_q, enc_d, errc_q, errc_d;
    logic               push, pop;
    assign c    = bus.in_class;
    assign f3   = bus.in_funct3;
    assign imm  = bus.in_imm;
    assign simm = $signed(bus.in_imm);
    assign alt  = bus.in_alt;
    always_comb begin
        u_rd     = c inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd7, 4'd8};
        u_rs1    = c inside {4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        u_rs2    = c inside {4'd4, 4'd6, 4'd8};
        is_shift = c == 4'd7 && f3[1:0] == 2'b01;
        i_ok     = simm >= -32'sd2048 && simm <= 32'sd2047;
        reg_bad  = (u_rd && bus.in_rd[4]) || (u_rs1 && bus.in_rs1[4]) || (u_rs2 && bus.in_rs2[4]);
        f3_bad   = (c == 4'd4 && f3[2:1] == 2'b01) || (c == 4'd5 && (f3 == 3'd3 || f3[2:1] == 2'b11)) ||
                   (c == 4'd6 && f3 >= 3'd3) || (c == 4'd3 && f3 != 3'd0);
        imm_bad  = is_shift ? imm[31:5] != 27'd0 :
                   (c inside {4'd3, 4'd5, 4'd6, 4'd7}) ? !i_ok :
                   c == 4'd4 ? simm < -32'sd4096 || simm > 32'sd4094 || imm[0] :
                   c == 4'd2 ? simm < -32'sd1048576 || simm > 32'sd1048574 || imm[0] :
                   (c inside {4'd0, 4'd1}) ? imm[11:0] != 12'd0 : 1'b0;
        alt_bad  = alt && !((c == 4'd8 && (f3 == 3'd0 || f3 == 3'd5)) || (c == 4'd7 && f3 == 3'd5));
        err      = c >= 4'd9 || reg_bad || f3_bad || imm_bad || alt_bad;
        rd       = u_rd ? bus.in_rd : 5'd0;
        rs1      = u_rs1 ? bus.in_rs1 : 5'd0;
        rs2      = u_rs2 ? bus.in_rs2 : 5'd0;
        f3_f     = (c inside {4'd0, 4'd1, 4'd2, 4'd3}) ? 3'd0 : f3;
        opc      = c == 4'd0 ? 7'h37 : c == 4'd1 ? 7'h17 : c == 4'd2 ? 7'h6F : c == 4'd3 ? 7'h67 :
                   c == 4'd4 ? 7'h63 : c == 4'd5 ? 7'h03 : c == 4'd6 ? 7'h23 : c == 4'd7 ? 7'h13 : 7'h33;
        case (c)
            4'd0, 4'd1: word = {imm[31:12], rd, opc};
            4'd2:       word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
            4'd4:       word = {imm[12], imm[10:5], rs2, rs1, f3_f, imm[4:1], imm[11], opc};
            4'd6:       word = {imm[11:5], rs2, rs1, f3_f, imm[4:0], opc};
            4'd8:       word = {1'b0, alt, 5'd0, rs2, rs1, f3_f, rd, opc};
            default:    word = is_shift ? {1'b0, alt, 5'd0, imm[4:0], rs1, f3_f, rd, opc}
                                        : {imm[11:0], rs1, f3_f, rd, opc};
        endcase
        if (err) word = 32'd0;
    end
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;
    assign cnt_d         = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    assign enc_d         = (push && !err && ~&enc_q) ? enc_q + CNT_W'(1) : enc_q;
    assign errc_d        = (push && err && ~&errc_q) ? errc_q + CNT_W'(1) : errc_q;
    assign head          = mem_q[rp_q];
    assign bus.in_ready  = cnt_q != (AW+1)'(DEPTH);
    assign bus.out_valid = cnt_q != '0;
    assign bus.out_instr = bus.out_valid ? head[31:0] : 32'd0;
    assign bus.out_err   = bus.out_valid && head[32];
    assign bus.enc_count = enc_q;
    assign bus.err_count = errc_q;
    // Storage is left unreset; the head is masked by out_valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= {err, word};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            enc_q  <= '0;
            errc_q <= '0;
        end else begin
            wp_q   <= push ? wp_q + AW'(1) : wp_q;
            rp_q   <= pop ? rp_q + AW'(1) : rp_q;
            cnt_q  <= cnt_d;
            enc_q  <= enc_d;
            errc_q <= errc_d;
        end
    end
endmodule

// File: doc/rv32e_instruction_encoder.md
Name: rv32e_instruction_encoder

Overview:
Streaming RV32E instruction encoder, the inverse of the core's instruction decoder. It accepts decoded micro-op fields (op class, register indices, funct3, alt bit, immediate) on a valid/ready port and checks RV32E legality. It packs each legal request into a 32-bit instruction word and queues the result in an output FIFO with its own valid/ready port. It is used by the debug/program-loader path to inject instructions and by verification to generate golden encodings.

Parameters:
DEPTH, 4, output FIFO entries (power of 2, ≥2)
CNT_W, 16, width of the saturating statistics counters

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  encoder can accept a request
in_class  in  4  0=LUI 1=AUIPC 2=JAL 3=JALR 4=BRANCH 5=LOAD 6=STORE 7=OP_IMM 8=OP, 9-15 illegal
in_rd  in  5  destination register index
in_rs1  in  5  source 1 index
in_rs2  in  5  source 2 index
in_funct3  in  3  funct3 field
in_alt  in  1  funct7[5] (SUB/SRA/SRAI)
in_imm  in  32  signed immediate, byte offset for branches/jumps
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_instr  out  32  encoded word (0 when out_err=1)
out_err  out  1  head request was illegal
enc_count  out  CNT_W  legal words accepted, saturating
err_count  out  CNT_W  illegal requests accepted, saturating

Behaviour:
- Reset (async assert, sync release): FIFO empty, out_valid=0, out_instr=0, out_err=0, enc_count=0, err_count=0, in_ready=1 on the first cycle after release.
- Accept = in_valid & in_ready. Encoding is combinational from the input fields and is written into the FIFO at the accept edge. out_valid rises in the cycle after that edge (latency 1).
- in_ready = !full. There is no pass-through when full, even if out_ready=1.
- Pop = out_valid & out_ready. A simultaneous push and pop leaves the count unchanged. Pop on empty and push on full cannot occur.
- Read/write pointers wrap modulo DEPTH. The count is log2(DEPTH)+1 bits wide.
- out_instr and out_err stay stable while out_valid=1 and out_ready=0.
- Opcodes: LUI 0x37, AUIPC 0x17, JAL 0x6F, JALR 0x67, BRANCH 0x63, LOAD 0x03, STORE 0x23, OP_IMM 0x13, OP 0x33.
- Immediate packing:
  - I: imm[11:0]→[31:20]
  - S: imm[11:5]→[31:25], imm[4:0]→[11:7]
  - B: imm[12|10:5]→[31:25], imm[4:1|11]→[11:7]
  - U: imm[31:12]→[31:12]
  - J: imm[20|10:1|11|19:12]→[31:12]
- Shifts (OP_IMM funct3 1/5): imm[4:0]→[24:20], in_alt→bit 30, all other funct7 bits 0.
- Fields only. rd is written for LUI/AUIPC/JAL/JALR/LOAD/OP_IMM/OP; rs1 for all except LUI/AUIPC/JAL; rs2 for BRANCH/STORE/OP. Unused fields are encoded as 0. funct3 is forced to 0 for JALR.
- Illegal conditions, any of which sets err:
  - Any used register index >15.
  - in_class ≥9.
  - BRANCH funct3 2 or 3.
  - LOAD funct3 3, 6 or 7.
  - STORE funct3 ≥3.
  - JALR funct3≠0.
  - I/S immediate outside −2048..2047.
  - B immediate outside −4096..4094 or odd.
  - J immediate outside −1048576..1048574 or odd.
  - U immediate with imm[11:0]≠0.
  - Shift immediate outside 0..31.
  - in_alt=1 except OP funct3 0/5 or OP_IMM funct3 5.
- An illegal request is still accepted and queued with out_err=1 and out_instr=0. Ordering is preserved.
- enc_count or err_count increments at the accept edge and holds at 2^CNT_W−1.
- rst_n asserted mid-stream discards all queued entries and clears the counters immediately, without waiting for a clock edge.

Test Plan:
- OP_IMM funct3=0 rd=1 rs1=0 imm=5 → out_instr=0x00500093, out_err=0, out_valid one cycle after accept, enc_count=1.
- OP funct3=0 alt=1 rd=3 rs1=1 rs2=2 → 0x402081B3; BRANCH funct3=0 rs1=1 rs2=2 imm=−4 → 0xFE208EE3.
- JAL rd=1 imm=2048 → 0x001000EF; JAL imm=3 → out_err=1, out_instr=0, err_count=1.
- OP rd=16 and OP_IMM imm=2048 → both out_err=1, legal requests queued between them emerge in order.
- out_ready=0 with 5 back-to-back requests (DEPTH=4) → in_ready=0 after the 4th accept. Then hold out_ready=1 while in_valid=1 → drain in order with no loss or duplication.
- Assert rst_n=0 with 3 entries queued → out_valid=0, counters 0 immediately, in_ready=1 after release.
